multi_dir_signal_ctrl: RTL and testbench
========================================

# multi_dir_signal_ctrl

Parametrised N-direction intersection controller. It rotates a protected green phase round-robin across `NUM_DIR` approaches, separated by yellow and all-red clearance phases. Pedestrian walk/clear intervals are served concurrently with the parallel approach's green. Directed emergency pre-emption truncates the running phase safely and holds green on the requested approach. It sits at the top of the intersection datapath and drives lamp drivers directly.

## Interface
- `NUM_DIR`, 4: number of approaches, 2..8.
- `GREEN_T`, 10: green duration in cycles; must be ≥ `PED_WALK_T + PED_CLEAR_T`.
- `YELLOW_T`, 3: yellow duration in cycles, ≥1.
- `ALL_RED_T`, 2: all-red clearance in cycles, ≥1.
- `PED_WALK_T`, 5: steady walk in cycles, ≥1.
- `PED_CLEAR_T`, 3: flashing don't-walk in cycles, ≥1.
- `clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `ped_req`, in, NUM_DIR: pedestrian button per crosswalk (crosswalk i runs parallel to approach i); level or pulse.
- `emerg_req`, in, 1: emergency pre-emption request, level.
- `emerg_dir`, in, clog2(NUM_DIR): approach requested for pre-emption; values ≥ NUM_DIR are ignored.
- `red`, `yellow`, `green`, out, NUM_DIR each: vehicle lamps per approach.
- `ped_walk`, `ped_flash`, out, NUM_DIR each: walk and flashing don't-walk per crosswalk; both 0 means steady don't-walk.
- `active_dir`, out, clog2(NUM_DIR): approach currently owning the green/yellow phase.
- `emerg_active`, out, 1: high while in EMERG_GREEN.

## Operation
- States: ALL_RED, GREEN, YELLOW, EMERG_GREEN, EMERG_YELLOW.
- Each timed state lasts exactly its parameter in cycles. The timer loads T-1 on entry, and the state exits on the edge where timer==0.
- ALL_RED exit, normal case: go to GREEN with `active_dir` ← (`active_dir`+1) mod NUM_DIR.
- ALL_RED exit with a valid `emerg_req`: go to EMERG_GREEN with `active_dir` ← `emerg_dir`, sampled at that edge.
- GREEN → YELLOW on timeout.
- GREEN with a valid `emerg_req` and `emerg_dir`≠`active_dir`: go to YELLOW on the next edge (truncation).
- GREEN with `emerg_dir`==`active_dir`: go to EMERG_GREEN directly, with no lamp change.
- YELLOW → ALL_RED on timeout; never truncated.
- EMERG_GREEN holds while `emerg_req` is high, with the timer frozen. On deassertion, go to EMERG_YELLOW (`YELLOW_T`), then ALL_RED. Normal rotation then resumes at `active_dir`+1.
- `emerg_dir` changing during EMERG_GREEN is ignored until the next ALL_RED.
- Pedestrian latch:
  - `ped_pending[i]` is set by `ped_req[i]` on any edge.
  - On entry to GREEN for approach d, serve crosswalk d if `ped_pending[d]` or `ped_req[d]` is high at that edge, then clear `ped_pending[d]`.
  - A request arriving later in the same green is re-latched for the next rotation.
- Served green: `ped_walk[d]`=1 for the first `PED_WALK_T` cycles of GREEN, then `ped_flash[d]`=1 for `PED_CLEAR_T` cycles, then both 0.
- Truncation of a served green: walk and flash drop to 0 immediately on entering YELLOW, and `ped_pending[d]` is re-set.
- No pedestrian service in EMERG_GREEN; requests stay latched.
- Lamps:
  - Exactly one of red/yellow/green is high per approach.
  - Approaches other than `active_dir` are red.
  - In ALL_RED, all approaches are red.
- Outputs are a Moore decode of registered state, timer, `active_dir` and serve flag.

## Timing
- Reset values:
  - state ALL_RED, timer `ALL_RED_T`-1, `active_dir` NUM_DIR-1.
  - `red` all 1; `yellow`, `green`, `ped_walk`, `ped_flash` all 0; `emerg_active` 0; `ped_pending` 0.
- After reset release: ALL_RED for `ALL_RED_T` cycles, then GREEN on approach 0.
- Emergency latency is at most `YELLOW_T`+`ALL_RED_T`+1 cycles from assertion to EMERG_GREEN, or 1 cycle when `emerg_dir`==`active_dir` in GREEN.
- Reset mid-phase returns to the reset state asynchronously; latched pedestrian requests are lost.

## Structure
- `signal_ctrl_pkg` holds the state enum, the `DIR_W`=clog2(NUM_DIR) localparam helper and the timer width function (clog2 of the max duration + 1).
- One sub-module, `phase_timer`, provides load, freeze, decrement and zero flag.
- Add elaboration-time assertions for the parameter ranges and the `GREEN_T` constraint.

## Test plan
All scenarios use NUM_DIR=3, GREEN_T=8, YELLOW_T=3, ALL_RED_T=2, PED_WALK_T=4, PED_CLEAR_T=2.

- Reset, no inputs, 60 cycles → green rotates 0,1,2,0. Each green is 8 cycles, each yellow 3, each all-red 2. Green 0 starts 2 cycles after release.
- `ped_req[1]` pulsed during green 0 → `ped_walk[1]` high for the first 4 cycles of green 1, `ped_flash[1]` for the next 2, both 0 for the last 2.
- `emerg_req`=1, `emerg_dir`=2 in cycle 3 of green 0 → yellow 0 starts next cycle, then all-red 2, then EMERG_GREEN on approach 2 with `emerg_active`=1. Deassert → yellow 2 (3), all-red (2), then green 0.
- Emergency for approach 1 during a served walk on crosswalk 0 → walk drops with yellow entry; crosswalk 0 is served again on the next green 0.
- Emergency for `active_dir` during GREEN → `emerg_active` is 1 after 1 cycle, lamps are unchanged, and the green holds beyond 8 cycles.
- Reset asserted mid-yellow, and `emerg_dir`=3 asserted → immediate all-red with outputs at reset values; `emerg_dir`=3 causes no pre-emption.

Source files
------------

// File: rtl/signal_ctrl_pkg.sv
// Shared types and sizing helpers for the intersection signal controller.
package signal_ctrl_pkg;

  typedef enum logic [2:0] {
    StAllRed,
    StGreen,
    StYellow,
    StEmergGreen,
    StEmergYellow
  } state_e;

  // Width of a direction index; at least one bit even for tiny configurations.
  function automatic int unsigned dir_w(input int unsigned num_dir);
    return (num_dir > 1) ? $clog2(num_dir) : 1;
  endfunction

  // Timer width wide enough to hold the longest duration itself.
  function automatic int unsigned timer_w(input int unsigned max_dur);
    return (max_dur > 0) ? $clog2(max_dur + 1) : 1;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counting phase timer with load, freeze and a zero flag.
module phase_timer #(
  parameter int unsigned Width    = 4,
  parameter int unsigned ResetVal = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             freeze_i,
  output logic [Width-1:0] cnt_o,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load wins over freeze; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (!freeze_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= Width'(ResetVal);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/multi_dir_signal_ctrl.sv
// Round-robin N-approach intersection controller with pedestrian service
// and directed emergency pre-emption. All outputs decode registered state.
module multi_dir_signal_ctrl
  import signal_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIR     = 4,
  parameter int unsigned GREEN_T     = 10,
  parameter int unsigned YELLOW_T    = 3,
  parameter int unsigned ALL_RED_T   = 2,
  parameter int unsigned PED_WALK_T  = 5,
  parameter int unsigned PED_CLEAR_T = 3
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_DIR-1:0]         ped_req_i,
  input  logic                       emerg_req_i,
  input  logic [dir_w(NUM_DIR)-1:0]  emerg_dir_i,
  output logic [NUM_DIR-1:0]         red_o,
  output logic [NUM_DIR-1:0]         yellow_o,
  output logic [NUM_DIR-1:0]         green_o,
  output logic [NUM_DIR-1:0]         ped_walk_o,
  output logic [NUM_DIR-1:0]         ped_flash_o,
  output logic [dir_w(NUM_DIR)-1:0]  active_dir_o,
  output logic                       emerg_active_o
);

  localparam int unsigned DIR_W   = dir_w(NUM_DIR);
  localparam int unsigned MAX_GY  = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
  localparam int unsigned MAX_DUR = (MAX_GY > ALL_RED_T) ? MAX_GY : ALL_RED_T;
  localparam int unsigned TMR_W   = timer_w(MAX_DUR);

  // Timer thresholds: walk while timer >= WALK_END, flash while in [FLASH_END, WALK_END).
  localparam logic [TMR_W-1:0] WALK_END  = TMR_W'(GREEN_T - PED_WALK_T);
  localparam logic [TMR_W-1:0] FLASH_END = TMR_W'(GREEN_T - PED_WALK_T - PED_CLEAR_T);

  if (NUM_DIR < 2 || NUM_DIR > 8) begin : gen_chk_num_dir
    $fatal(1, "NUM_DIR must be in 2..8");
  end
  if (YELLOW_T < 1 || ALL_RED_T < 1 || PED_WALK_T < 1 || PED_CLEAR_T < 1) begin : gen_chk_dur
    $fatal(1, "YELLOW_T, ALL_RED_T, PED_WALK_T and PED_CLEAR_T must be >= 1");
  end
  if (GREEN_T < PED_WALK_T + PED_CLEAR_T) begin : gen_chk_green
    $fatal(1, "GREEN_T must cover PED_WALK_T + PED_CLEAR_T");
  end

  state_e             state_q, state_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [NUM_DIR-1:0] pend_q, pend_d;
  logic               serve_q, serve_d;

  logic               tmr_load, tmr_freeze, tmr_zero;
  logic [TMR_W-1:0]   tmr_load_val, tmr_cnt;

  logic               emerg_valid;
  logic [DIR_W-1:0]   next_dir;

  assign emerg_valid = emerg_req_i && (32'(emerg_dir_i) < NUM_DIR);
  assign next_dir    = (dir_q == DIR_W'(NUM_DIR - 1)) ? '0 : dir_q + DIR_W'(1);

  phase_timer #(
    .Width    (TMR_W),
    .ResetVal (ALL_RED_T - 1)
  ) u_phase_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .freeze_i   (tmr_freeze),
    .cnt_o      (tmr_cnt),
    .zero_o     (tmr_zero)
  );

  // Phase sequencing, pedestrian latch and service decision.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    serve_d      = serve_q;
    pend_d       = pend_q | ped_req_i;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_freeze   = 1'b0;
    unique case (state_q)
      StAllRed: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (emerg_valid) begin
            state_d = StEmergGreen;
            dir_d   = emerg_dir_i;
          end else begin
            state_d          = StGreen;
            dir_d            = next_dir;
            serve_d          = pend_q[next_dir] | ped_req_i[next_dir];
            pend_d[next_dir] = 1'b0;
            tmr_load_val     = TMR_W'(GREEN_T - 1);
          end
        end
      end
      StGreen: begin
        if (emerg_valid || tmr_zero) begin
          // Emergency for the running approach keeps its green without a lamp change.
          state_d      = (emerg_valid && (emerg_dir_i == dir_q)) ? StEmergGreen : StYellow;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(YELLOW_T - 1);
          serve_d      = 1'b0;
          // A cut-short crossing is owed another service.
          if (emerg_valid && serve_q) begin
            pend_d[dir_q] = 1'b1;
          end
        end
      end
      StYellow, StEmergYellow: begin
        if (tmr_zero) begin
          state_d      = StAllRed;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(ALL_RED_T - 1);
        end
      end
      StEmergGreen: begin
        if (!emerg_req_i) begin
          state_d      = StEmergYellow;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(YELLOW_T - 1);
        end else begin
          tmr_freeze = 1'b1;
        end
      end
      default: state_d = StAllRed;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StAllRed;
      dir_q   <= DIR_W'(NUM_DIR - 1);
      pend_q  <= '0;
      serve_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      serve_q <= serve_d;
    end
  end

  // Moore lamp and pedestrian decode.
  always_comb begin
    red_o       = '1;
    yellow_o    = '0;
    green_o     = '0;
    ped_walk_o  = '0;
    ped_flash_o = '0;
    unique case (state_q)
      StGreen, StEmergGreen: begin
        red_o[dir_q]   = 1'b0;
        green_o[dir_q] = 1'b1;
      end
      StYellow, StEmergYellow: begin
        red_o[dir_q]    = 1'b0;
        yellow_o[dir_q] = 1'b1;
      end
      default: ;
    endcase
    if ((state_q == StGreen) && serve_q) begin
      ped_walk_o[dir_q]  = (tmr_cnt >= WALK_END);
      ped_flash_o[dir_q] = (tmr_cnt < WALK_END) && (tmr_cnt >= FLASH_END);
    end
  end

  assign active_dir_o   = dir_q;
  assign emerg_active_o = (state_q == StEmergGreen);

endmodule

// File: tb/tb_multi_dir_signal_ctrl.sv
// Randomized bench for multi_dir_signal_ctrl against a phase/age reference model.
module tb_multi_dir_signal_ctrl;

  localparam int unsigned NUM_DIR     = 3;
  localparam int unsigned GREEN_T     = 8;
  localparam int unsigned YELLOW_T    = 3;
  localparam int unsigned ALL_RED_T   = 2;
  localparam int unsigned PED_WALK_T  = 4;
  localparam int unsigned PED_CLEAR_T = 2;

  localparam int PhAr = 0;
  localparam int PhG  = 1;
  localparam int PhY  = 2;
  localparam int PhEG = 3;
  localparam int PhEY = 4;

  logic       clk_i;
  logic       reset_i;
  logic [2:0] ped_req_i;
  logic       emerg_req_i;
  logic [1:0] emerg_dir_i;
  logic [2:0] red_o, yellow_o, green_o, ped_walk_o, ped_flash_o;
  logic [1:0] active_dir_o;
  logic       emerg_active_o;

  int total = 0;
  int bad   = 0;

  // Reference model: phase, cycles already spent in it, owner, requests.
  int         m_phase;
  int         m_age;
  int         m_dir;
  logic [2:0] m_pend;
  logic       m_serve;

  multi_dir_signal_ctrl #(
    .NUM_DIR     (NUM_DIR),
    .GREEN_T     (GREEN_T),
    .YELLOW_T    (YELLOW_T),
    .ALL_RED_T   (ALL_RED_T),
    .PED_WALK_T  (PED_WALK_T),
    .PED_CLEAR_T (PED_CLEAR_T)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .ped_req_i      (ped_req_i),
    .emerg_req_i    (emerg_req_i),
    .emerg_dir_i    (emerg_dir_i),
    .red_o          (red_o),
    .yellow_o       (yellow_o),
    .green_o        (green_o),
    .ped_walk_o     (ped_walk_o),
    .ped_flash_o    (ped_flash_o),
    .active_dir_o   (active_dir_o),
    .emerg_active_o (emerg_active_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_phase = PhAr;
    m_age   = 0;
    m_dir   = NUM_DIR - 1;
    m_pend  = '0;
    m_serve = 1'b0;
  endtask

  // Advance the model across one clock edge with the inputs seen at that edge.
  task automatic m_step(input logic [2:0] ped, input logic ereq, input logic [1:0] edir);
    logic       ev;
    logic [2:0] pn;
    int         nd;
    ev = ereq && (int'(edir) < NUM_DIR);
    pn = m_pend | ped;
    case (m_phase)
      PhAr: begin
        if (m_age == ALL_RED_T - 1) begin
          m_age = 0;
          if (ev) begin
            m_phase = PhEG;
            m_dir   = int'(edir);
          end else begin
            nd      = (m_dir + 1) % NUM_DIR;
            m_serve = m_pend[nd] | ped[nd];
            pn[nd]  = 1'b0;
            m_phase = PhG;
            m_dir   = nd;
          end
        end else m_age++;
      end
      PhG: begin
        if (ev || m_age == GREEN_T - 1) begin
          if (ev && m_serve) pn[m_dir] = 1'b1;
          m_phase = (ev && int'(edir) == m_dir) ? PhEG : PhY;
          m_age   = 0;
          m_serve = 1'b0;
        end else m_age++;
      end
      PhY, PhEY: begin
        if (m_age == YELLOW_T - 1) begin
          m_phase = PhAr;
          m_age   = 0;
        end else m_age++;
      end
      PhEG: begin
        if (!ereq) begin
          m_phase = PhEY;
          m_age   = 0;
        end
      end
      default: ;
    endcase
    m_pend = pn;
  endtask

  task automatic compare_all(input string tag);
    logic [2:0] er, ey, eg, ew, ef;
    er = '1; ey = '0; eg = '0; ew = '0; ef = '0;
    if (m_phase == PhG || m_phase == PhEG) begin
      er[m_dir] = 1'b0;
      eg[m_dir] = 1'b1;
    end
    if (m_phase == PhY || m_phase == PhEY) begin
      er[m_dir] = 1'b0;
      ey[m_dir] = 1'b1;
    end
    if (m_phase == PhG && m_serve) begin
      ew[m_dir] = (m_age < PED_WALK_T);
      ef[m_dir] = (m_age >= PED_WALK_T) && (m_age < PED_WALK_T + PED_CLEAR_T);
    end
    check_val({tag, ".red"}, 32'(red_o), 32'(er));
    check_val({tag, ".yellow"}, 32'(yellow_o), 32'(ey));
    check_val({tag, ".green"}, 32'(green_o), 32'(eg));
    check_val({tag, ".walk"}, 32'(ped_walk_o), 32'(ew));
    check_val({tag, ".flash"}, 32'(ped_flash_o), 32'(ef));
    check_val({tag, ".dir"}, 32'(active_dir_o), 32'(m_dir));
    check_val({tag, ".emerg"}, 32'(emerg_active_o), 32'(m_phase == PhEG));
  endtask

  task automatic drive_random();
    for (int i = 0; i < 3; i++) ped_req_i[i] = ($urandom_range(0, 15) == 0);
    if (!emerg_req_i) emerg_req_i = ($urandom_range(0, 59) == 0);
    else              emerg_req_i = ($urandom_range(0, 19) != 0);
    if ($urandom_range(0, 7) == 0) emerg_dir_i = 2'($urandom_range(0, 3));
  endtask

  initial begin
    int         first_green;
    logic       prev_g;
    int         starts[$];
    int         exp_dirs[4];

    exp_dirs = '{0, 1, 2, 0};
    reset_i     = 1'b1;
    ped_req_i   = '0;
    emerg_req_i = 1'b0;
    emerg_dir_i = '0;
    m_reset();
    repeat (3) @(negedge clk_i);
    compare_all("reset");
    reset_i = 1'b0;

    // Idle rotation straight out of reset.
    first_green = -1;
    prev_g      = 1'b0;
    for (int k = 0; k < 60; k++) begin
      m_step(ped_req_i, emerg_req_i, emerg_dir_i);
      @(negedge clk_i);
      compare_all("idle");
      if ((|green_o) && !prev_g) begin
        if (first_green < 0) first_green = k + 1;
        starts.push_back(int'(active_dir_o));
      end
      prev_g = |green_o;
    end
    check_val("first_green_cycle", 32'(first_green), 32'd2);
    check_val("green_count_ok", 32'(starts.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < starts.size()) check_val("green_order", 32'(starts[i]), 32'(exp_dirs[i]));
    end

    // Random traffic with occasional asynchronous resets.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_i     = 1'b1;
        ped_req_i   = '0;
        emerg_req_i = 1'b1;
        emerg_dir_i = 2'd3;
        m_reset();
        #1;
        compare_all("arst");
        @(negedge clk_i);
        compare_all("rst_hold");
        reset_i = 1'b0;
      end else begin
        drive_random();
      end
      m_step(ped_req_i, emerg_req_i, emerg_dir_i);
      @(negedge clk_i);
      compare_all("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
